// File: rtl/dcmac_0_ts_ctx_pkg.sv
// rtl/dcmac_0_ts_ctx_pkg.sv - context/record types and next-context function for the ts context updater
// DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN enables backwards-timestamp detection in ctx_next().
package dcmac_0_ts_ctx_pkg;

    localparam int NUM_ID_P = 6;
    localparam int ID_W     = (NUM_ID_P == 1) ? 1 : $clog2(NUM_ID_P);
    localparam int TS_W     = 32;
    localparam int CNT_W    = 16;
    localparam int CTX_W    = 1 + CNT_W + TS_W;

    typedef struct packed {
        logic             seen;
        logic [CNT_W-1:0] count;
        logic [TS_W-1:0]  last_ts;
    } ctx_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TS_W-1:0]  delta;
        logic [CNT_W-1:0] count;
        logic             first;
        logic             err;
    } out_rec_t;

    localparam int REC_W = $bits(out_rec_t);

    typedef struct packed {
        ctx_t     ctx;
        out_rec_t rec;
    } ctx_upd_t;

    function automatic ctx_upd_t ctx_next(input ctx_t cur, input logic [ID_W-1:0] id,
                                          input logic [TS_W-1:0] ts);
        ctx_upd_t        r;
        logic [TS_W-1:0] delta;
        delta         = ts - cur.last_ts;
        r.ctx.seen    = 1'b1;
        r.ctx.count   = cur.seen ? (cur.count + CNT_W'(1)) : CNT_W'(1);
        r.ctx.last_ts = ts;
        r.rec.id      = id;
        r.rec.delta   = cur.seen ? delta : '0;
        r.rec.count   = r.ctx.count;
        r.rec.first   = !cur.seen;
        r.rec.err     = 1'b0;
`ifdef DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN
        // A modular backwards step keeps the old reference so later deltas stay sane
        if (cur.seen && delta[TS_W-1]) begin
            r.rec.err     = 1'b1;
            r.rec.delta   = '0;
            r.ctx.last_ts = cur.last_ts;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/dcmac_0_ts_ctx_ofifo.sv
// rtl/dcmac_0_ts_ctx_ofifo.sv - synchronous record FIFO with occupancy count
module dcmac_0_ts_ctx_ofifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNTW  = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [W-1:0]    push_data,
    input  logic            pop,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CNTW-1:0] count
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (count_q != CNTW'(DEPTH));

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/dcmac_0_ts_ctx_updater.sv
// rtl/dcmac_0_ts_ctx_updater.sv - per-ID timestamp context read-modify-write with delta record FIFO
// DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN adds out_err reporting and the err_cnt port.
module dcmac_0_ts_ctx_updater
    import dcmac_0_ts_ctx_pkg::*;
#(
    parameter  int NUM_ID     = NUM_ID_P,
    parameter  int TSW        = TS_W,
    parameter  int CNTW       = CNT_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDW        = (NUM_ID == 1) ? 1 : $clog2(NUM_ID),
    localparam int CW         = 1 + CNTW + TSW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IDW-1:0]  in_id,
    input  logic [TSW-1:0]  in_ts,
    output logic [IDW-1:0]  ctx_rd_id,
    output logic            ctx_ena,
    output logic [CW-1:0]   ctx_dat,
    input  logic [CW-1:0]   ctx_q,
    input  logic            ctx_init,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDW-1:0]  out_id,
    output logic [TSW-1:0]  out_delta,
    output logic [CNTW-1:0] out_count,
    output logic            out_first,
    output logic            out_err
`ifdef DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN
   ,output logic [15:0]     err_cnt
`endif
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [TSW-1:0]  s1_ts_q, s1_ts_d;
    logic [FCW-1:0]  fifo_count;
    logic            accept;
    ctx_upd_t        upd;
    out_rec_t        rec_out;

    // Credit check counts the S1 event so its push can never find the FIFO full
    assign in_ready = !rst && !ctx_init &&
                      ((32'(fifo_count) + 32'(s1_valid_q)) < 32'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = accept;
        s1_id_d    = accept ? in_id : s1_id_q;
        s1_ts_d    = accept ? in_ts : s1_ts_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_ts_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_ts_q    <= s1_ts_d;
        end
    end

    // Same-ID back-to-back events see the previous write through the memory bypass
    assign upd       = ctx_next(ctx_t'(ctx_q), s1_id_q, s1_ts_q);
    assign ctx_rd_id = in_id;
    assign ctx_ena   = s1_valid_q;
    assign ctx_dat   = s1_valid_q ? upd.ctx : '0;

    dcmac_0_ts_ctx_ofifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_q),
        .push_data (upd.rec),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (rec_out),
        .count     (fifo_count)
    );

    assign out_id    = rec_out.id;
    assign out_delta = rec_out.delta;
    assign out_count = rec_out.count;
    assign out_first = rec_out.first;
    assign out_err   = rec_out.err;

`ifdef DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s1_valid_q && upd.rec.err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dcmac_0_ts_ctx_updater.sv
// tb/tb_dcmac_0_ts_ctx_updater.sv - directed/table bench for dcmac_0_ts_ctx_updater with a bypassing context memory model
module tb_dcmac_0_ts_ctx_updater;

    localparam int IDW  = 3;
    localparam int TSW  = 32;
    localparam int CNTW = 16;
    localparam int CW   = 1 + CNTW + TSW;
    localparam int RW   = IDW + TSW + CNTW + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [IDW-1:0]  in_id;
    logic [TSW-1:0]  in_ts;
    logic [IDW-1:0]  ctx_rd_id;
    logic            ctx_ena;
    logic [CW-1:0]   ctx_dat;
    logic [CW-1:0]   ctx_q;
    logic            ctx_init;
    logic            out_valid, out_ready;
    logic [IDW-1:0]  out_id;
    logic [TSW-1:0]  out_delta;
    logic [CNTW-1:0] out_count;
    logic            out_first, out_err;
`ifdef DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN
    logic [15:0]     err_cnt;
`endif

    always #5 clk = ~clk;

    dcmac_0_ts_ctx_updater dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_ts     (in_ts),
        .ctx_rd_id (ctx_rd_id),
        .ctx_ena   (ctx_ena),
        .ctx_dat   (ctx_dat),
        .ctx_q     (ctx_q),
        .ctx_init  (ctx_init),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_delta (out_delta),
        .out_count (out_count),
        .out_first (out_first),
        .out_err   (out_err)
`ifdef DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN
       ,.err_cnt   (err_cnt)
`endif
    );

    // Context memory: one-cycle read, write-to-read bypass, clear while ctx_init
    logic [CW-1:0]  mem [8];
    logic [IDW-1:0] rd_id_prev;
    logic           preload;
    always @(posedge clk) begin
        if (ctx_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (ctx_ena) begin
            mem[rd_id_prev] <= ctx_dat;
        end
        if (preload) mem[3] <= {1'b1, 16'hFFFF, 32'd5};
        ctx_q      <= (ctx_ena && (rd_id_prev == ctx_rd_id)) ? ctx_dat : mem[ctx_rd_id];
        rd_id_prev <= ctx_rd_id;
    end

    logic [RW-1:0] got_rec [$];
    logic [CW-1:0] got_ctx [$];
    bit            mon_en;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid && out_ready) got_rec.push_back({out_id, out_delta, out_count, out_first, out_err});
            if (ctx_ena) got_ctx.push_back(ctx_dat);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [IDW-1:0] id, input logic [TSW-1:0] ts);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_id    = id;
        in_ts    = ts;
        n        = 0;
        acc      = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_recs(input string name, input logic [RW-1:0] exp [$]);
        chk({name, "_nrec"}, 64'(got_rec.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_rec.size(); i++)
            chk($sformatf("%s_rec%0d", name, i), 64'(got_rec[i]), 64'(exp[i]));
    endtask

    function automatic logic [RW-1:0] rec(input logic [IDW-1:0] id, input logic [TSW-1:0] d,
                                          input logic [CNTW-1:0] c, input logic f, input logic e);
        return {id, d, c, f, e};
    endfunction

    typedef struct {
        logic [IDW-1:0]  id;
        logic [TSW-1:0]  ts;
        logic [TSW-1:0]  delta;
        logic [CNTW-1:0] cnt;
        logic            first;
    } vec_t;

    vec_t           vt [9];
    logic [TSW-1:0] bp_ts [6];
    logic [RW-1:0]  exp_q [$];

    initial begin
        vt[0] = '{3'd2, 32'd100,         32'd0,    16'd1, 1'b1};
        vt[1] = '{3'd2, 32'd250,         32'd150,  16'd2, 1'b0};
        vt[2] = '{3'd0, 32'hFFFF_FFF0,   32'd0,    16'd1, 1'b1};
        vt[3] = '{3'd0, 32'h10,          32'h20,   16'd2, 1'b0};
        vt[4] = '{3'd3, 32'd9,           32'd4,    16'd0, 1'b0};
        vt[5] = '{3'd5, 32'd7,           32'd0,    16'd1, 1'b1};
        vt[6] = '{3'd2, 32'd1000,        32'd750,  16'd3, 1'b0};
        vt[7] = '{3'd4, 32'd60,          32'd5,    16'd2, 1'b0};
        vt[8] = '{3'd0, 32'h10,          32'd0,    16'd3, 1'b0};
        bp_ts[0] = 32'd10; bp_ts[1] = 32'd20; bp_ts[2] = 32'd35;
        bp_ts[3] = 32'd60; bp_ts[4] = 32'd100; bp_ts[5] = 32'd101;

        in_valid = 1'b0; in_id = '0; in_ts = '0; out_ready = 1'b1;
        ctx_init = 1'b0; rst = 1'b1; preload = 1'b0; mon_en = 1'b0;

        cycles(3);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ctx_ena", 64'(ctx_ena), 64'd0);
        chk("rst_out_fields", 64'({out_id, out_delta, out_count, out_first, out_err}), 64'd0);

        @(posedge clk); #1;
        rst = 1'b0; ctx_init = 1'b1;
        @(negedge clk);
        chk("init_in_ready", 64'(in_ready), 64'd0);
        cycles(3);
        ctx_init = 1'b0;
        @(negedge clk);
        chk("post_init_in_ready", 64'(in_ready), 64'd1);

        // Latency: accept at N, write in N+1, out_valid in N+2
        @(posedge clk); #1;
        in_valid = 1'b1; in_id = 3'd4; in_ts = 32'd55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_ctx_ena", 64'(ctx_ena), 64'd1);
        chk("lat_ctx_dat", 64'(ctx_dat), 64'({1'b1, 16'd1, 32'd55}));
        chk("lat_out_valid_n1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_out_valid_n2", 64'(out_valid), 64'd1);
        chk("lat_rec", 64'({out_id, out_delta, out_count, out_first, out_err}), 64'(rec(3'd4, 0, 16'd1, 1'b1, 1'b0)));
        @(negedge clk);
        chk("lat_ctx_ena_idle", 64'(ctx_ena), 64'd0);

        // Table: back-to-back events, modular wrap, counter wrap via preloaded context
        @(posedge clk); #1;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        got_rec.delete(); got_ctx.delete(); mon_en = 1'b1;
        foreach (vt[i]) send(vt[i].id, vt[i].ts);
        cycles(6);
        chk("tbl_nrec", 64'(got_rec.size()), 64'd9);
        chk("tbl_nctx", 64'(got_ctx.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_rec.size())
                chk($sformatf("tbl_rec%0d", i), 64'(got_rec[i]),
                    64'(rec(vt[i].id, vt[i].delta, vt[i].cnt, vt[i].first, 1'b0)));
            if (i < got_ctx.size())
                chk($sformatf("tbl_ctx%0d", i), 64'(got_ctx[i]), 64'({1'b1, vt[i].cnt, vt[i].ts}));
        end

        // Backpressure: six events on id 1 with out_ready low
        got_rec.delete(); got_ctx.delete();
        out_ready = 1'b0;
        begin
            int  idx;
            int  n;
            bit  acc;
            idx = 0;
            for (int c = 0; c < 10; c++) begin
                in_valid = (idx < 6); in_id = 3'd1; in_ts = bp_ts[(idx < 6) ? idx : 0];
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                if (acc) idx++;
            end
            chk("bp_accepted_stalled", 64'(idx), 64'd4);
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
            n = 0;
            while (idx < 6 && n < 50) begin
                in_valid = 1'b1; in_id = 3'd1; in_ts = bp_ts[idx];
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                if (acc) idx++;
                n++;
            end
            in_valid = 1'b0;
            chk("bp_accepted_total", 64'(idx), 64'd6);
        end
        cycles(8);
        exp_q = '{rec(3'd1, 32'd0, 16'd1, 1'b1, 1'b0), rec(3'd1, 32'd10, 16'd2, 1'b0, 1'b0),
                  rec(3'd1, 32'd15, 16'd3, 1'b0, 1'b0), rec(3'd1, 32'd25, 16'd4, 1'b0, 1'b0),
                  rec(3'd1, 32'd40, 16'd5, 1'b0, 1'b0), rec(3'd1, 32'd1, 16'd6, 1'b0, 1'b0)};
        chk_recs("bp", exp_q);

        // ctx_init rising with an event in S1
        got_rec.delete(); got_ctx.delete();
        send(3'd4, 32'd100);
        ctx_init = 1'b1;
        in_valid = 1'b1; in_id = 3'd4; in_ts = 32'd200;
        @(negedge clk);
        chk("init_mid_in_ready", 64'(in_ready), 64'd0);
        chk("init_mid_ctx_ena", 64'(ctx_ena), 64'd1);
        chk("init_mid_ctx_dat", 64'(ctx_dat), 64'({1'b1, 16'd3, 32'd100}));
        cycles(2);
        @(negedge clk);
        chk("init_hold_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        ctx_init = 1'b0;
        send(3'd4, 32'd200);
        cycles(5);
        exp_q = '{rec(3'd4, 32'd40, 16'd3, 1'b0, 1'b0), rec(3'd4, 32'd0, 16'd1, 1'b1, 1'b0)};
        chk_recs("init", exp_q);

`ifdef DCMAC_TS_CTX_UPDATER_REORDER_CHK_EN
        got_rec.delete(); got_ctx.delete();
        send(3'd1, 32'd500);
        send(3'd1, 32'd400);
        cycles(5);
        exp_q = '{rec(3'd1, 32'd0, 16'd1, 1'b1, 1'b0), rec(3'd1, 32'd0, 16'd2, 1'b0, 1'b1)};
        chk_recs("reorder", exp_q);
        if (got_ctx.size() == 2) chk("reorder_ctx", 64'(got_ctx[1]), 64'({1'b1, 16'd2, 32'd500}));
        else chk("reorder_nctx", 64'(got_ctx.size()), 64'd2);
        chk("reorder_err_cnt", 64'(err_cnt), 64'd1);
`endif

        // Synchronous reset with records queued
        mon_en = 1'b0;
        out_ready = 1'b0;
        send(3'd2, 32'd5);
        send(3'd2, 32'd6);
        cycles(2);
        @(negedge clk);
        chk("mid_rst_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_fields", 64'({out_id, out_delta, out_count, out_first, out_err}), 64'd0);
        chk("mid_rst_ctx_ena", 64'(ctx_ena), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
